// File: rtl/clk_en_ctrl.sv
// clk_en_ctrl: programmable divided-clock and strobe generator with start/stop sequencing
module clk_en_ctrl #(
  parameter int CW = 16,
  parameter int DEF_PERIOD = 4,
  parameter int DEF_HIGH = 2,
  parameter int DEF_PHASE = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [CW-1:0] cfg_period,
  input  logic [CW-1:0] cfg_high,
  input  logic [CW-1:0] cfg_phase,
  output logic          div_clk,
  output logic          rise_tick,
  output logic          fall_tick,
  output logic          running,
  output logic          cfg_err
);
  typedef enum logic [1:0] {IDLE, DELAY, RUN} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n, dcnt, dcnt_n;
  logic [CW-1:0] per, hi, ph, per_n, hi_n, ph_n;
  logic [CW-1:0] p_per, p_hi, p_ph, p_per_n, p_hi_n, p_ph_n;
  logic pend, pend_n, xfer, legal, wrap, apply, ld, set_idle;
  logic div_d, rise_d, fall_d, run_d;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      dcnt <= '0;
      per <= CW'(DEF_PERIOD);
      hi <= CW'(DEF_HIGH);
      ph <= CW'(DEF_PHASE);
      p_per <= '0;
      p_hi <= '0;
      p_ph <= '0;
      pend <= 1'b0;
      div_clk <= 1'b0;
      rise_tick <= 1'b0;
      fall_tick <= 1'b0;
      running <= 1'b0;
      cfg_ready <= 1'b1;
      cfg_err <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      dcnt <= dcnt_n;
      per <= per_n;
      hi <= hi_n;
      ph <= ph_n;
      p_per <= p_per_n;
      p_hi <= p_hi_n;
      p_ph <= p_ph_n;
      pend <= pend_n;
      div_clk <= div_d;
      rise_tick <= rise_d;
      fall_tick <= fall_d;
      running <= run_d;
      cfg_ready <= !pend_n;
      cfg_err <= xfer && !legal;
    end
  end
  always_comb begin
    xfer = cfg_valid && cfg_ready;
    legal = cfg_period >= CW'(2) && cfg_high != '0 && cfg_high < cfg_period;
    wrap = state == RUN && cnt == per - CW'(1);
    apply = pend && (wrap || (state == DELAY && !enable));
    ld = state != IDLE && xfer && legal;
    set_idle = state == IDLE && xfer && legal;
    per_n = apply ? p_per : set_idle ? cfg_period : per;
    hi_n = apply ? p_hi : set_idle ? cfg_high : hi;
    ph_n = apply ? p_ph : set_idle ? cfg_phase : ph;
    p_per_n = ld ? cfg_period : p_per;
    p_hi_n = ld ? cfg_high : p_hi;
    p_ph_n = ld ? cfg_phase : p_ph;
    pend_n = ld || (pend && !apply);
    state_n = state;
    cnt_n = cnt;
    dcnt_n = dcnt;
    case (state)
      IDLE: if (enable) begin
        state_n = ph_n == '0 ? RUN : DELAY;
        cnt_n = '0;
        dcnt_n = '0;
      end
      DELAY: if (!enable) state_n = IDLE;
        else if (dcnt == ph - CW'(1)) begin
          state_n = RUN;
          cnt_n = '0;
        end else dcnt_n = dcnt + CW'(1);
      RUN: if (wrap) begin
        cnt_n = '0;
        state_n = enable ? RUN : IDLE;
      end else cnt_n = cnt + CW'(1);
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    run_d = state_n == RUN;
    div_d = run_d && cnt_n < hi_n;
    rise_d = run_d && cnt_n == '0;
    fall_d = run_d && cnt_n == hi_n;
  end
endmodule

// File: tb/tb_clk_en_ctrl.sv
// tb_clk_en_ctrl: scoreboard bench for clk_en_ctrl with directed per-cycle expectations
module tb_clk_en_ctrl;
  localparam int CW = 16;
  localparam logic [5:0] IDL = 6'b000010;
  typedef struct {
    logic [5:0] e;
    int id;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1, enable = 1'b0, cfg_valid = 1'b0;
  logic [CW-1:0] cfg_period = '0, cfg_high = '0, cfg_phase = '0;
  logic cfg_ready, div_clk, rise_tick, fall_tick, running, cfg_err;
  exp_t q[$];
  int n_chk = 0, n_fail = 0, cyc = 0;
  clk_en_ctrl #(.CW(CW), .DEF_PERIOD(4), .DEF_HIGH(2), .DEF_PHASE(0)) dut (
    .clk(clk), .rst(rst), .enable(enable), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_period(cfg_period), .cfg_high(cfg_high), .cfg_phase(cfg_phase),
    .div_clk(div_clk), .rise_tick(rise_tick), .fall_tick(fall_tick),
    .running(running), .cfg_err(cfg_err)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t x;
      logic [5:0] a;
      x = q.pop_front();
      a = {running, div_clk, rise_tick, fall_tick, cfg_ready, cfg_err};
      n_chk++;
      if (a !== x.e) begin
        n_fail++;
        $display("FAIL outputs@cyc%0d {run,div,rise,fall,rdy,err} got %b want %b", x.id, a, x.e);
      end
    end
  end
  task automatic tick(input logic [5:0] e);
    exp_t x;
    x.e = e;
    x.id = cyc;
    q.push_back(x);
    cyc++;
    @(posedge clk);
    #1;
  endtask
  task automatic run(input int p, input int h, input int n, input int c0, input logic rdy, input logic err);
    for (int i = 0; i < n; i++) begin
      int c;
      c = (c0 + i) % p;
      tick({1'b1, c < h, c == 0, c == h, rdy, err});
    end
  endtask
  task automatic cfg(input logic v, input int p, input int h, input int ph);
    cfg_valid = v;
    cfg_period = CW'(p);
    cfg_high = CW'(h);
    cfg_phase = CW'(ph);
  endtask
  initial begin
    #1;
    tick(IDL);
    tick(IDL);
    rst = 1'b0;
    repeat (3) tick(IDL);
    enable = 1'b1;
    run(4, 2, 13, 0, 1, 0);
    enable = 1'b0;
    run(4, 2, 3, 1, 1, 0);
    tick(IDL);
    tick(IDL);
    enable = 1'b1;
    run(4, 2, 1, 0, 1, 0);
    enable = 1'b0;
    run(4, 2, 1, 1, 1, 0);
    enable = 1'b1;
    run(4, 2, 7, 2, 1, 0);
    enable = 1'b0;
    run(4, 2, 3, 1, 1, 0);
    tick(IDL);
    cfg(1, 10, 3, 5);
    tick(IDL);
    cfg(0, 0, 0, 0);
    tick(IDL);
    enable = 1'b1;
    repeat (5) tick(IDL);
    run(10, 3, 20, 0, 1, 0);
    enable = 1'b0;
    tick(IDL);
    cfg(1, 4, 2, 0);
    tick(IDL);
    cfg(0, 0, 0, 0);
    enable = 1'b1;
    run(4, 2, 5, 0, 1, 0);
    cfg(1, 6, 1, 2);
    run(4, 2, 1, 1, 0, 0);
    cfg(1, 8, 4, 0);
    run(4, 2, 2, 2, 0, 0);
    run(6, 1, 1, 0, 1, 0);
    run(6, 1, 1, 1, 0, 0);
    cfg(0, 0, 0, 0);
    run(6, 1, 4, 2, 0, 0);
    run(8, 4, 8, 0, 1, 0);
    cfg(1, 4, 2, 0);
    run(8, 4, 1, 0, 0, 0);
    cfg(0, 0, 0, 0);
    run(8, 4, 7, 1, 0, 0);
    run(4, 2, 4, 0, 1, 0);
    cfg(1, 1, 1, 0);
    run(4, 2, 1, 0, 1, 1);
    cfg(1, 4, 0, 0);
    run(4, 2, 1, 1, 1, 1);
    cfg(1, 4, 4, 0);
    run(4, 2, 1, 2, 1, 1);
    cfg(0, 0, 0, 0);
    run(4, 2, 1, 3, 1, 0);
    run(4, 2, 4, 0, 1, 0);
    enable = 1'b0;
    tick(IDL);
    cfg(1, 10, 3, 5);
    tick(IDL);
    cfg(0, 0, 0, 0);
    enable = 1'b1;
    tick(IDL);
    tick(IDL);
    rst = 1'b1;
    tick(IDL);
    rst = 1'b0;
    run(4, 2, 6, 0, 1, 0);
    cfg(1, 6, 3, 0);
    run(4, 2, 1, 2, 0, 0);
    cfg(0, 0, 0, 0);
    run(4, 2, 1, 3, 0, 0);
    run(6, 3, 2, 0, 1, 0);
    rst = 1'b1;
    tick(IDL);
    rst = 1'b0;
    run(4, 2, 4, 0, 1, 0);
    enable = 1'b0;
    tick(IDL);
    @(negedge clk);
    #1;
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain left %0d want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
